// File: rtl/edge_detect_mc.sv
// edge_detect_mc
//   Multi-channel edge detector. Each of WIDTH asynchronous inputs is passed
//   through a SYNC_STAGES-deep synchroniser, then a rising/falling/both edge
//   is detected according to that channel's 2-bit mode. A detected edge gives
//   a one-cycle pulse, sets a sticky flag and bumps a saturating counter.
//   A global warm-up phase after reset suppresses edge detection until the
//   synchroniser and previous-value flops hold real input history.
//
// Optional feature (macro EDGE_DEBOUNCE_EN):
//   When defined, a per-channel debounce filter sits between the synchroniser
//   output and the previous-value flop. The filtered value only follows the
//   input after it has differed for DEB_CYCLES consecutive cycles, and warm-up
//   is lengthened by DEB_CYCLES.
//
// Ports:
//   clk          in   clock, rising edge
//   resetn       in   asynchronous active-low reset
//   din          in   [WIDTH]      raw asynchronous inputs
//   mode         in   [2*WIDTH]    per-channel mode: 00 off, 01 rise, 10 fall, 11 both
//   clr          in   [WIDTH]      per-channel clear of sticky flag and counter
//   irq_en       in   [WIDTH]      per-channel interrupt enable
//   cnt_sel      in   [SEL_W]      channel selected for counter readout
//   edge_pulse   out  [WIDTH]      registered one-cycle edge pulses
//   event_sticky out  [WIDTH]      sticky event flags
//   cnt_rd       out  [CNT_W]      registered counter of channel cnt_sel
//   irq          out               OR of enabled sticky flags
//   ready        out               high once warm-up is complete

module edge_detect_mc #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int DEB_CYCLES  = 4,
    localparam int SEL_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [WIDTH-1:0]   din,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   clr,
    input  logic [WIDTH-1:0]   irq_en,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [WIDTH-1:0]   edge_pulse,
    output logic [WIDTH-1:0]   event_sticky,
    output logic [CNT_W-1:0]   cnt_rd,
    output logic               irq,
    output logic               ready
);

`ifdef EDGE_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    localparam int WARM_LEN = SYNC_STAGES + 1 + (DEB_ON ? DEB_CYCLES : 0);
    localparam int WCW      = $clog2(WARM_LEN);

    typedef enum logic {WARM, RUN} state_t;

    state_t             state;
    logic [WCW-1:0]     warm_cnt;
    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   f;
    logic [WIDTH-1:0]   p;
    logic [WIDTH-1:0]   hit;
    logic [CNT_W-1:0]   cnt [WIDTH];
    logic [CNT_W-1:0]   rd_mux;

    // Synchroniser chain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= din;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb s = sync_q[SYNC_STAGES-1];

`ifdef EDGE_DEBOUNCE_EN
    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [DCW-1:0]   deb_cnt [WIDTH];
    logic [WIDTH-1:0] filt;

    // Filter follows s only after DEB_CYCLES consecutive differing cycles;
    // any agreement with the current filtered value restarts the count.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s[i] != filt[i]) begin
                    if (deb_cnt[i] == DCW'(DEB_CYCLES - 1)) begin
                        filt[i]    <= s[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb f = filt;
`else
    always_comb f = s;
`endif

    // Edge qualification; suppressed entirely during warm-up
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            hit[i] = (state == RUN) &
                     ((mode[2*i]   &  f[i] & ~p[i]) |
                      (mode[2*i+1] & ~f[i] &  p[i]));
        end
    end

    // Warm-up FSM with registered ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= WARM;
            warm_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            case (state)
                WARM: begin
                    if (warm_cnt == WCW'(WARM_LEN - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                RUN: ready <= 1'b1;
                default: state <= WARM;
            endcase
        end
    end

    // Per-channel previous value, pulse, sticky flag and counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p            <= '0;
            edge_pulse   <= '0;
            event_sticky <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            p          <= f;
            edge_pulse <= hit;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                // set has priority over clear
                if (hit[i])      event_sticky[i] <= 1'b1;
                else if (clr[i]) event_sticky[i] <= 1'b0;

                // clear restarts the count, counting the coincident edge
                if (clr[i])                         cnt[i] <= hit[i] ? CNT_W'(1) : '0;
                else if (hit[i] && (cnt[i] != '1))  cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Readout mux; unmatched selects yield zero
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_sel == SEL_W'(i)) rd_mux = cnt[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_rd <= '0;
        else         cnt_rd <= rd_mux;
    end

    assign irq = |(event_sticky & irq_en);

endmodule

// File: tb/tb_edge_detect_mc.sv
// Scoreboard bench for edge_detect_mc (WIDTH=4, SYNC_STAGES=2, CNT_W=4).
// Stimulus pushes each expected edge_pulse (cycle number + channel mask)
// into a queue; a monitor on the falling edge pops and compares whenever
// the DUT presents a non-zero pulse. Static state is checked directly.

module tb_edge_detect_mc;

    logic       clk;
    logic       resetn;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] irq_en;
    logic [1:0] cnt_sel;
    logic [3:0] edge_pulse;
    logic [3:0] event_sticky;
    logic [3:0] cnt_rd;
    logic       irq;
    logic       ready;

    edge_detect_mc #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .din(din),
        .mode(mode),
        .clr(clr),
        .irq_en(irq_en),
        .cnt_sel(cnt_sel),
        .edge_pulse(edge_pulse),
        .event_sticky(event_sticky),
        .cnt_rd(cnt_rd),
        .irq(irq),
        .ready(ready)
    );

    typedef struct {
        int         cyc;
        logic [3:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-zero pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (edge_pulse != 4'b0000) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected cyc=%0d act=%b required=none", cyc, edge_pulse);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.mask != edge_pulse) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d act=%b required cyc=%0d mask=%b",
                             cyc, edge_pulse, e.cyc, e.mask);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d act=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // din changed at this negedge shows on edge_pulse after 3 more posedges
    task automatic push_exp(input logic [3:0] m);
        exp_t e;
        e.cyc  = cyc + 3;
        e.mask = m;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d act=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn  = 1'b0;
        din     = 4'b1111;
        mode    = 8'hFF;
        clr     = 4'b0000;
        irq_en  = 4'b0000;
        cnt_sel = 2'd0;

        // ---- Reset and warm-up with inputs already high ----
        step(3);
        chk("rst_ready",  32'(ready), 0);
        chk("rst_pulse",  32'(edge_pulse), 0);
        chk("rst_sticky", 32'(event_sticky), 0);
        chk("rst_cnt",    32'(cnt_rd), 0);
        chk("rst_irq",    32'(irq), 0);
        resetn = 1'b1;
        step(1); chk("warm_ready_1", 32'(ready), 0);
        step(1); chk("warm_ready_2", 32'(ready), 0);
        step(1); chk("warm_ready_3", 32'(ready), 1);
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("warm_sticky", 32'(event_sticky), 0);
            chk("warm_cnt",    32'(cnt_rd), 0);
        end

        // ---- Per-mode detection ----
        mode = 8'h00;
        din  = 4'b0000;
        step(5);
        chk("masked_sticky", 32'(event_sticky), 0);
        mode = 8'b00_11_10_01;
        din  = 4'b1111; push_exp(4'b0101);
        step(5);
        din  = 4'b0000; push_exp(4'b0110);
        step(5);
        chk("mode_sticky", 32'(event_sticky), 32'h7);
        chk("mode_irq_off", 32'(irq), 0);
        begin
            int exp_cnt[4] = '{1, 1, 2, 0};
            for (int ch = 0; ch < 4; ch++) begin
                cnt_sel = 2'(ch);
                step(1);
                chk($sformatf("mode_cnt%0d", ch), 32'(cnt_rd), 32'(exp_cnt[ch]));
            end
        end
        clr = 4'b1111; step(1); clr = 4'b0000;
        chk("clr_all_sticky", 32'(event_sticky), 0);
        cnt_sel = 2'd2; step(1);
        chk("clr_all_cnt2", 32'(cnt_rd), 0);

        // ---- Saturation on ch1 ----
        mode    = 8'h04;
        cnt_sel = 2'd1;
        for (int k = 1; k <= 20; k++) begin
            din = 4'b0010; push_exp(4'b0010);
            step(2);
            din = 4'b0000;
            step(2);
            chk($sformatf("sat_cnt_k%0d", k), 32'(cnt_rd), 32'((k > 15) ? 15 : k));
        end
        chk("sat_sticky1", 32'(event_sticky[1]), 1);

        // ---- Clear versus set on ch2 ----
        clr = 4'b1111; step(1); clr = 4'b0000;
        mode    = 8'h10;
        cnt_sel = 2'd2;
        for (int k = 0; k < 2; k++) begin
            din = 4'b0100; push_exp(4'b0100);
            step(3);
            din = 4'b0000;
            step(3);
        end
        chk("cs_cnt_pre", 32'(cnt_rd), 2);
        din = 4'b0100; push_exp(4'b0100);
        step(2);
        clr = 4'b0100;           // lands on the same edge as hit[2]
        step(1);
        clr = 4'b0000;
        chk("cs_sticky_set_wins", 32'(event_sticky[2]), 1);
        step(1);
        chk("cs_cnt_restart", 32'(cnt_rd), 1);
        din = 4'b0000;
        step(3);
        clr = 4'b0100; step(1); clr = 4'b0000;
        chk("cs_clr_sticky", 32'(event_sticky[2]), 0);
        step(1);
        chk("cs_clr_cnt", 32'(cnt_rd), 0);

        // ---- Interrupt masking ----
        clr = 4'b1111; step(1); clr = 4'b0000;
        irq_en = 4'b0100;
        mode   = 8'h01;
        din    = 4'b0001; push_exp(4'b0001);
        step(5);
        chk("irq_sticky0", 32'(event_sticky), 32'h1);
        chk("irq_masked", 32'(irq), 0);
        irq_en = 4'b0101;
        #1;
        chk("irq_enabled", 32'(irq), 1);
        din = 4'b0000;
        step(3);
        chk("irq_hold", 32'(irq), 1);
        clr = 4'b0001; step(1); clr = 4'b0000;
        chk("irq_cleared", 32'(irq), 0);

        // ---- Async reset mid-run ----
        irq_en  = 4'b1111;
        mode    = 8'hFF;
        cnt_sel = 2'd0;
        din = 4'b1111; push_exp(4'b1111);
        step(4);
        din = 4'b0000; push_exp(4'b1111);
        step(4);
        din = 4'b1111; push_exp(4'b1111);
        step(3);
        chk("mid_pulse",  32'(edge_pulse), 32'hF);
        chk("mid_cnt",    32'(cnt_rd), 2);
        chk("mid_ready",  32'(ready), 1);
        chk("mid_irq",    32'(irq), 1);
        din = 4'b0000;           // falls now in flight, must be dropped
        #2;
        resetn = 1'b0;
        #1;
        chk("async_pulse",  32'(edge_pulse), 0);
        chk("async_sticky", 32'(event_sticky), 0);
        chk("async_cnt",    32'(cnt_rd), 0);
        chk("async_ready",  32'(ready), 0);
        chk("async_irq",    32'(irq), 0);
        din = 4'b1111;
        step(3);
        resetn = 1'b1;
        step(1); chk("rewarm_ready_1", 32'(ready), 0);
        step(1); chk("rewarm_ready_2", 32'(ready), 0);
        step(1); chk("rewarm_ready_3", 32'(ready), 1);
        step(3);
        chk("rewarm_sticky", 32'(event_sticky), 0);
        chk("rewarm_cnt",    32'(cnt_rd), 0);

        step(5);
        chk("scoreboard_drain", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_detect_mc.md
Name: edge_detect_mc

Overview:
- Multi-channel, parametrised edge detector.
- Synchronises WIDTH asynchronous inputs and detects a rising, falling or either edge per channel, selected by a per-channel mode.
- Each detected edge produces a one-cycle pulse, sets a sticky event bit and increments a per-channel saturating counter.
- Sits between raw external inputs and the control/interrupt logic; an irq output aggregates the enabled sticky bits.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=1).
- CNT_W, 8, width of each per-channel event counter (>=1).
- DEB_CYCLES, 4, debounce stability window in cycles; used only with the optional feature (>=1).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- resetn  in  1  asynchronous active-low reset.
- din  in  WIDTH  raw asynchronous inputs, one bit per channel.
- mode  in  2*WIDTH  per-channel mode, channel i at [2i+1:2i]: 00 disabled, 01 rising, 10 falling, 11 both.
- clr  in  WIDTH  per-channel clear of sticky bit and counter, sampled each clk.
- irq_en  in  WIDTH  per-channel interrupt enable.
- cnt_sel  in  max(1,$clog2(WIDTH))  channel index for the counter readout.
- edge_pulse  out  WIDTH  registered one-cycle edge pulses.
- event_sticky  out  WIDTH  sticky event flags.
- cnt_rd  out  CNT_W  registered count of the channel at cnt_sel.
- irq  out  1  OR of (event_sticky & irq_en).
- ready  out  1  high once warm-up is complete.

Behaviour:
- Reset (resetn low, asynchronous): all synchroniser flops, previous-value flops, edge_pulse, event_sticky, counters, cnt_rd, ready and the warm-up counter clear to 0. irq is therefore 0.
- Pipeline per channel:
  - s = last synchroniser stage; p = s delayed by one cycle.
  - rise = s & ~p; fall = ~s & p.
  - hit = (mode[0] & rise) | (mode[1] & fall); edge_pulse <= hit.
- Latency: a din change that meets setup before edge 0 appears on edge_pulse for exactly one cycle, starting at edge SYNC_STAGES and deasserting at edge SYNC_STAGES+1.
- Warm-up state machine (global), two states:
  - WARM: entered on reset. A counter counts SYNC_STAGES+1 clk edges after resetn deasserts. hit is forced to 0, so no pulses, sticky sets or count increments occur. Synchroniser and p flops still load normally. ready=0.
  - RUN: entered when the count completes; ready=1. The block stays in RUN until the next reset.
  - Warm-up prevents a spurious edge when din is already high at reset release.
- mode is used unregistered. A change takes effect on the next edge computation; mode 00 masks the pulse but the synchroniser and p continue tracking.
- Sticky, per channel, each clk:
  - clr=1 and hit=0: sticky <= 0.
  - hit=1: sticky <= 1; set wins over a simultaneous clr.
- Counter, per channel, each clk:
  - clr=1 and hit=1: counter <= 1.
  - clr=1 and hit=0: counter <= 0.
  - hit=1 and clr=0: counter increments, saturating at 2^CNT_W-1 (no wrap).
- Readout: cnt_rd <= counter[cnt_sel] on every clk, so it shows the counter value from the previous cycle. cnt_sel >= WIDTH returns 0.
- irq is combinational from registered signals only (glitch-free).
- Reset mid-operation: everything clears immediately and warm-up restarts; events in flight are dropped.
- Channels are fully independent; simultaneous edges on all channels are all counted in the same cycle.

Optional Feature:
- Macro: EDGE_DEBOUNCE_EN.
- Defined: a per-channel debounce stage sits between the synchroniser output and p.
  - The filtered value f changes only after the synchroniser output has differed from f for DEB_CYCLES consecutive cycles.
  - Any return to the f value resets that channel's stability counter.
  - Edge detection uses f; latency increases by DEB_CYCLES cycles.
  - Pulses shorter than DEB_CYCLES cycles are ignored.
  - Warm-up length becomes SYNC_STAGES+DEB_CYCLES+1 cycles.
- Undefined: f = synchroniser output; no debounce counters are instantiated.

Test Plan (WIDTH=4, SYNC_STAGES=2, CNT_W=4):
- Reset and warm-up:
  - Hold din=4'b1111 through reset; release resetn; mode=all 11.
  - Required: ready rises after 3 edges; edge_pulse stays 0; event_sticky stays 0; cnt_rd stays 0.
- Per-mode detection:
  - Channels 0..3 in modes 01/10/11/00; toggle din 0->1->0 with each level held 5 cycles.
  - Required: ch0 pulses once on the rise; ch1 once on the fall; ch2 twice; ch3 never. Each pulse is 1 cycle wide, 2 edges after the din change.
- Saturation:
  - 20 rising edges on ch1 (mode 01); cnt_sel=1.
  - Required: cnt_rd stops at 15 and does not wrap to 0; event_sticky[1]=1.
- Clear versus set:
  - Assert clr[2] in the same cycle that hit[2] is asserted.
  - Required: event_sticky[2] stays 1 and counter[2] reads 1. A later clr[2] alone gives sticky 0 and count 0.
- Interrupt masking:
  - irq_en=4'b0100; events occur on ch0 only.
  - Required: irq=0. Set irq_en[0]=1 and irq=1 on the same cycle. clr[0] gives irq=0 on the next cycle.
- Async reset mid-run:
  - Drop resetn between clk edges while pulses are in flight.
  - Required: all outputs go to 0 immediately, without waiting for a clk edge; warm-up repeats after release.
